// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game-control slice.
package genius_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_OFF,
    WAIT_PRESS,
    WAIT_RELEASE,
    ROUND_OK,
    WIN,
    LOSE
  } state_t;

  localparam int SEQ_LEN = 16;

  localparam logic [3:0] C_G      = 4'b0001;
  localparam logic [3:0] C_R      = 4'b0010;
  localparam logic [3:0] C_Y      = 4'b0100;
  localparam logic [3:0] C_B      = 4'b1000;
  localparam logic [3:0] LEDS_OFF = 4'b0000;
  localparam logic [3:0] LEDS_ALL = 4'b1111;

  // True when more than one bit of v is set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/genius_timer.sv
// Dwell timer: loaded with a cycle count on every state change, done on the last cycle.
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Loading value-1 makes done fire in exactly the load_val-th cycle of the dwell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = en && (cnt == '0);

endmodule

// File: rtl/genius_seq_player.sv
// Genius game controller: shows the ROM sequence round by round and checks the player's presses.
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int ON_CYCLES      = 50_000_000,
  parameter int OFF_CYCLES     = 25_000_000,
  parameter int GAP_CYCLES     = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] seq_addr,
  input  logic [3:0] seq_data,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic [4:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int MAX_AB  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CD  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_ALL) + 1;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    idx;
  logic [3:0]    btn_latch;
  logic [TW-1:0] tload_val;
  logic          tload;
  logic          ten;
  logic          tdone;
  logic          last;
  logic          press;
  logic          bad_press;

  assign seq_addr  = idx;
  assign last      = ({1'b0, idx} == (round - 5'd1));
  assign press     = (botoes != 4'd0);
  assign bad_press = multi_hot(botoes) || (botoes != seq_data);
  assign tload     = (state_nxt != state);

  genius_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tload),
    .en       (ten),
    .load_val (tload_val),
    .done     (tdone)
  );

  // Next-state decision for the game FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WIN, LOSE: if (start) state_nxt = SHOW_ON;
      SHOW_ON:         if (tdone) state_nxt = SHOW_OFF;
      SHOW_OFF:        if (tdone) state_nxt = last ? WAIT_PRESS : SHOW_ON;
      WAIT_PRESS: begin
        if (press)      state_nxt = bad_press ? LOSE : WAIT_RELEASE;
        else if (tdone) state_nxt = LOSE;
      end
      WAIT_RELEASE:    if (!press) state_nxt = last ? ROUND_OK : WAIT_PRESS;
      ROUND_OK:        if (tdone) state_nxt = (round == 5'(SEQ_LEN)) ? WIN : SHOW_ON;
      default:         state_nxt = IDLE;
    endcase
  end

  // Dwell length and timer enable chosen for the state being entered / currently held.
  always_comb begin
    tload_val = TW'(1);
    ten       = 1'b0;
    case (state_nxt)
      SHOW_ON:    tload_val = TW'(ON_CYCLES);
      SHOW_OFF:   tload_val = TW'(OFF_CYCLES);
      WAIT_PRESS: tload_val = TW'(TIMEOUT_CYCLES);
      ROUND_OK:   tload_val = TW'(GAP_CYCLES);
      default:    tload_val = TW'(1);
    endcase
    case (state)
      SHOW_ON, SHOW_OFF, WAIT_PRESS, ROUND_OK: ten = 1'b1;
      default:                                 ten = 1'b0;
    endcase
  end

  // State register plus step index, round counter and the echoed button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      round     <= 5'd0;
      btn_latch <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, WIN, LOSE: begin
          if (start) begin
            round <= 5'd1;
            idx   <= 4'd0;
          end
        end
        SHOW_OFF:     if (tdone) idx <= last ? 4'd0 : idx + 4'd1;
        WAIT_PRESS:   if (press) btn_latch <= botoes;
        WAIT_RELEASE: if (!press && !last) idx <= idx + 4'd1;
        ROUND_OK: begin
          if (tdone && (round != 5'(SEQ_LEN))) begin
            round <= round + 5'd1;
            idx   <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state; in SHOW_ON the colour comes straight from the ROM
  // at the registered address so it lights in the same cycle the address is presented.
  always_comb begin
    leds = LEDS_OFF;
    busy = 1'b1;
    win  = 1'b0;
    lose = 1'b0;
    case (state)
      IDLE:         busy = 1'b0;
      SHOW_ON:      leds = seq_data;
      WAIT_RELEASE: leds = btn_latch;
      WIN: begin
        leds = LEDS_ALL;
        busy = 1'b0;
        win  = 1'b1;
      end
      LOSE: begin
        busy = 1'b0;
        lose = 1'b1;
      end
      default: leds = LEDS_OFF;
    endcase
  end

endmodule

// File: tb/tb_genius_seq_player.sv
// Directed testbench for genius_seq_player with a small sequence ROM model attached.
module tb_genius_seq_player;
  import genius_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic [4:0] round;
  logic       busy;
  logic       win;
  logic       lose;

  logic [3:0] rom [16];
  int total;
  int bad;

  genius_seq_player #(
    .ON_CYCLES      (4),
    .OFF_CYCLES     (2),
    .GAP_CYCLES     (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seq_addr (seq_addr),
    .seq_data (seq_data),
    .botoes   (botoes),
    .leds     (leds),
    .round    (round),
    .busy     (busy),
    .win      (win),
    .lose     (lose)
  );

  assign seq_data = rom[seq_addr];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // start is a single-cycle pulse; botoes holds its level afterwards.
  task automatic applyStimulus(input logic st, input logic [3:0] b, input int n);
    start  = st;
    botoes = b;
    tick(1);
    start = 1'b0;
    if (n > 1) tick(n - 1);
  endtask

  // Entered at the first SHOW_ON cycle; leaves at the first cycle of the following state.
  task automatic expectShow(input logic [3:0] c, input logic [3:0] addr, input logic pulse);
    for (int i = 0; i < 4; i++) begin
      checkOutput("show_on_leds", 32'(leds), 32'(c));
      checkOutput("show_addr", 32'(seq_addr), 32'(addr));
      if (pulse && (i == 0)) start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput("show_off_leds", 32'(leds), 32'(LEDS_OFF));
      tick(1);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    botoes = 4'd0;
    rom = '{C_G, C_Y, C_R, C_B, C_G, C_G, C_Y, C_R,
            C_B, C_B, C_Y, C_G, C_R, C_Y, C_B, C_R};

    // Reset, with start asserted during reset, then idle.
    start = 1'b1;
    tick(2);
    start = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_round", 32'(round), 32'd0);
    rst_n = 1'b1;
    tick(10);
    checkOutput("idle_leds", 32'(leds), 32'd0);
    checkOutput("idle_round", 32'(round), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_addr", 32'(seq_addr), 32'd0);
    checkOutput("idle_win", 32'(win), 32'd0);
    checkOutput("idle_lose", 32'(lose), 32'd0);

    // Start and round-1 show timing.
    applyStimulus(1'b1, 4'd0, 1);
    checkOutput("start_round", 32'(round), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    expectShow(C_G, 4'd0, 1'b0);

    // Round 1 correct press, gap, then round-2 show.
    applyStimulus(1'b0, C_G, 1);
    checkOutput("r1_echo", 32'(leds), 32'(C_G));
    applyStimulus(1'b0, 4'd0, 1);
    checkOutput("gap1_leds", 32'(leds), 32'd0);
    checkOutput("gap1_round", 32'(round), 32'd1);
    tick(2);
    checkOutput("gap3_round", 32'(round), 32'd1);
    tick(1);
    checkOutput("r2_round", 32'(round), 32'd2);
    expectShow(C_G, 4'd0, 1'b0);
    expectShow(C_Y, 4'd1, 1'b0);

    // Round 2: first step right, second step wrong.
    applyStimulus(1'b0, C_G, 1);
    checkOutput("r2_echo", 32'(leds), 32'(C_G));
    applyStimulus(1'b0, 4'd0, 1);
    checkOutput("r2_addr1", 32'(seq_addr), 32'd1);
    checkOutput("r2_wait_lose", 32'(lose), 32'd0);
    applyStimulus(1'b0, C_B, 1);
    checkOutput("wrong_lose", 32'(lose), 32'd1);
    checkOutput("wrong_busy", 32'(busy), 32'd0);
    checkOutput("wrong_leds", 32'(leds), 32'd0);
    checkOutput("wrong_win", 32'(win), 32'd0);
    applyStimulus(1'b1, 4'd0, 1);
    checkOutput("restart_round", 32'(round), 32'd1);
    checkOutput("restart_lose", 32'(lose), 32'd0);

    // Timeout exactly 20 cycles after entering WAIT_PRESS.
    expectShow(C_G, 4'd0, 1'b0);
    tick(19);
    checkOutput("timeout_early", 32'(lose), 32'd0);
    tick(1);
    checkOutput("timeout_lose", 32'(lose), 32'd1);

    // Two buttons at once.
    applyStimulus(1'b1, 4'd0, 1);
    expectShow(C_G, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1);
    checkOutput("multi_lose", 32'(lose), 32'd1);
    applyStimulus(1'b0, 4'd0, 1);
    checkOutput("multi_hold", 32'(lose), 32'd1);

    // Full 16-round game, with a start pulse during a show that must be ignored.
    applyStimulus(1'b1, 4'd0, 1);
    for (int r = 1; r <= 16; r++) begin
      for (int s = 0; s < r; s++) expectShow(rom[s], 4'(s), (r == 2) && (s == 0));
      for (int s = 0; s < r; s++) begin
        applyStimulus(1'b0, rom[s], 1);
        checkOutput("game_echo", 32'(leds), 32'(rom[s]));
        applyStimulus(1'b0, 4'd0, 1);
      end
      checkOutput("game_gap_round", 32'(round), 32'(r));
      tick(3);
      if (r < 16) begin
        checkOutput("game_next_round", 32'(round), 32'(r + 1));
        checkOutput("game_busy", 32'(busy), 32'd1);
      end
    end
    checkOutput("win_flag", 32'(win), 32'd1);
    checkOutput("win_leds", 32'(leds), 32'(LEDS_ALL));
    checkOutput("win_round", 32'(round), 32'd16);
    checkOutput("win_busy", 32'(busy), 32'd0);
    tick(5);
    checkOutput("win_hold", 32'(win), 32'd1);

    // Reset in the middle of WAIT_RELEASE.
    applyStimulus(1'b1, 4'd0, 1);
    checkOutput("post_win_round", 32'(round), 32'd1);
    checkOutput("post_win_win", 32'(win), 32'd0);
    expectShow(C_G, 4'd0, 1'b0);
    applyStimulus(1'b0, C_G, 1);
    checkOutput("rel_echo", 32'(leds), 32'(C_G));
    rst_n = 1'b0;
    tick(1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_round", 32'(round), 32'd0);
    checkOutput("midrst_leds", 32'(leds), 32'd0);
    checkOutput("midrst_addr", 32'(seq_addr), 32'd0);
    rst_n  = 1'b1;
    botoes = 4'd0;
    tick(2);
    checkOutput("after_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
